// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared register map, field indices, bus FSM encoding and
//               calendar helpers for the RTC bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam logic [7:0] c_ADDR_CTRL  = 8'h00;
    localparam logic [7:0] c_ADDR_SEC   = 8'h21;
    localparam logic [7:0] c_ADDR_MIN   = 8'h22;
    localparam logic [7:0] c_ADDR_HOUR  = 8'h23;
    localparam logic [7:0] c_ADDR_DATE  = 8'h24;
    localparam logic [7:0] c_ADDR_MONTH = 8'h25;
    localparam logic [7:0] c_ADDR_YEAR  = 8'h26;
    localparam logic [7:0] c_ADDR_DOW   = 8'h27;
    localparam logic [7:0] c_ADDR_WEEK  = 8'h28;

    // Time fields are stored in address order starting at c_ADDR_SEC
    localparam int c_NUM_FIELDS = 8;
    localparam int c_F_SEC   = 0;
    localparam int c_F_MIN   = 1;
    localparam int c_F_HOUR  = 2;
    localparam int c_F_DATE  = 3;
    localparam int c_F_MONTH = 4;
    localparam int c_F_YEAR  = 5;
    localparam int c_F_DOW   = 6;
    localparam int c_F_WEEK  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } bus_state_e;

    function automatic logic [7:0] field_min(input int idx);
        case (idx)
            c_F_DATE, c_F_MONTH, c_F_DOW, c_F_WEEK: return 8'h01;
            default:                                return 8'h00;
        endcase
    endfunction

    // BCD year mod 4: 10*hi + lo == 2*hi + lo (mod 4)
    function automatic logic [7:0] month_days(input logic [7:0] month, input logic [7:0] year);
        logic [4:0] yr_mod;
        yr_mod = {year[7:4], 1'b0} + {1'b0, year[3:0]};
        case (month)
            8'h02:                      return (yr_mod[1:0] == 2'b00) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input int idx, input logic [7:0] month,
                                             input logic [7:0] year);
        case (idx)
            c_F_SEC, c_F_MIN: return 8'h59;
            c_F_HOUR:         return 8'h23;
            c_F_DATE:         return month_days(month, year);
            c_F_MONTH:        return 8'h12;
            c_F_YEAR:         return 8'h99;
            c_F_DOW:          return 8'h07;
            default:          return 8'h52;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bcd_inc.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bcd_inc
// Description : Packed-BCD increment with wrap from max (or any invalid
//               value) back to min; carry flags the wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bcd_inc (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    output logic [7:0] next_value,
    output logic       carry
);

    logic w_bad_digit;

    assign w_bad_digit = (value[7:4] > 4'd9) || (value[3:0] > 4'd9);

    always_comb begin
        next_value = 8'h00;
        carry      = 1'b0;
        if (w_bad_digit || (value >= max)) begin
            next_value = min;
            carry      = 1'b1;
        end else if (value[3:0] == 4'd9) begin
            next_value = {value[7:4] + 4'd1, 4'h0};
        end else begin
            next_value = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_responder
// Description : BCD real-time clock behind an asynchronous multiplexed
//               address/data bus with a one-second prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_responder
    import rtc_pkg::*;
#(
    parameter int TICK_DIV    = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       ChipSelect,
    input  logic       Read,
    input  logic       Write,
    input  logic       AoD,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       tick
);

    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

    // Control bundle {AoD, Write, Read, ChipSelect}; strobes idle high
    logic [3:0]         r_ctl_sync [SYNC_STAGES];
    logic [7:0]         r_din_sync [SYNC_STAGES+1];
    logic               w_cs, w_rd, w_wr, w_aod;
    logic [7:0]         w_din;

    bus_state_e         r_state, w_next_state;
    logic               w_addr_wr, w_reg_wr;
    logic [7:0]         r_addr;
    logic               r_halt;
    logic               r_data_oe;
    logic [7:0]         r_data_out;
    logic [7:0]         w_rd_data;
    logic               w_addr_is_time;
    logic [2:0]         w_tidx;

    logic [c_PRE_W-1:0] r_pre;
    logic               r_tick, r_tick_pend;
    logic               w_tick_due, w_adv;

    logic [7:0]              r_time    [c_NUM_FIELDS];
    logic [7:0]              w_max     [c_NUM_FIELDS];
    logic [7:0]              w_inc_val [c_NUM_FIELDS];
    logic [c_NUM_FIELDS-1:0] w_carry, w_inc_en;
    logic                    w_en_min, w_en_hour, w_day_roll, w_en_month, w_en_year, w_en_week;

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_ctl_sync[i] <= 4'b0111;
            for (int i = 0; i <= SYNC_STAGES; i++) r_din_sync[i] <= 8'h00;
        end else begin
            r_ctl_sync[0] <= {AoD, Write, Read, ChipSelect};
            for (int i = 1; i < SYNC_STAGES; i++) r_ctl_sync[i] <= r_ctl_sync[i-1];
            r_din_sync[0] <= data_in;
            for (int i = 1; i <= SYNC_STAGES; i++) r_din_sync[i] <= r_din_sync[i-1];
        end
    end

    assign w_cs  = r_ctl_sync[SYNC_STAGES-1][0];
    assign w_rd  = r_ctl_sync[SYNC_STAGES-1][1];
    assign w_wr  = r_ctl_sync[SYNC_STAGES-1][2];
    assign w_aod = r_ctl_sync[SYNC_STAGES-1][3];
    // One stage older than the strobe: the bus value from just before Write rose
    assign w_din = r_din_sync[SYNC_STAGES];

    always_comb begin
        w_next_state = r_state;
        w_addr_wr    = 1'b0;
        w_reg_wr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs) begin
                    if (!w_wr)               w_next_state = w_aod ? ST_WDATA : ST_ADDR;
                    else if (w_aod && !w_rd) w_next_state = ST_RDATA;
                end
            end
            ST_ADDR: begin
                if (w_cs) begin
                    w_next_state = ST_IDLE;
                end else if (w_wr) begin
                    w_next_state = ST_IDLE;
                    w_addr_wr    = 1'b1;
                end
            end
            ST_WDATA: begin
                if (w_cs) begin
                    w_next_state = ST_IDLE;
                end else if (w_wr) begin
                    w_next_state = ST_IDLE;
                    w_reg_wr     = 1'b1;
                end
            end
            ST_RDATA: begin
                if (w_cs || w_rd) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_addr_is_time = (r_addr >= c_ADDR_SEC) && (r_addr <= c_ADDR_WEEK);
    assign w_tidx         = 3'(r_addr - c_ADDR_SEC);

    always_comb begin
        w_rd_data = 8'h00;
        if (r_addr == c_ADDR_CTRL)  w_rd_data = {7'd0, r_halt};
        else if (w_addr_is_time)    w_rd_data = r_time[w_tidx];
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= 8'h00;
            r_halt     <= 1'b0;
            r_data_oe  <= 1'b0;
            r_data_out <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (w_addr_wr) r_addr <= w_din;
            if (w_reg_wr && (r_addr == c_ADDR_CTRL)) r_halt <= w_din[0];
            r_data_oe  <= (w_next_state == ST_RDATA);
            r_data_out <= (w_next_state == ST_RDATA) ? w_rd_data : 8'h00;
        end
    end

    // A tick that lands on a bus write is held one cycle so the write wins
    assign w_tick_due = r_tick | r_tick_pend;
    assign w_adv      = w_tick_due & ~w_reg_wr & ~r_halt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_pre       <= '0;
            r_tick      <= 1'b0;
            r_tick_pend <= 1'b0;
        end else begin
            r_pre       <= (r_pre == c_PRE_LAST) ? '0 : r_pre + c_PRE_W'(1);
            r_tick      <= (r_pre == c_PRE_LAST);
            r_tick_pend <= w_tick_due & w_reg_wr;
        end
    end

    assign w_en_min   = w_adv      & w_carry[c_F_SEC];
    assign w_en_hour  = w_en_min   & w_carry[c_F_MIN];
    assign w_day_roll = w_en_hour  & w_carry[c_F_HOUR];
    assign w_en_month = w_day_roll & w_carry[c_F_DATE];
    assign w_en_year  = w_en_month & w_carry[c_F_MONTH];
    assign w_en_week  = w_day_roll & w_carry[c_F_DOW];
    assign w_inc_en   = {w_en_week, w_day_roll, w_en_year, w_en_month,
                         w_day_roll, w_en_hour, w_en_min, w_adv};

    generate
        for (genvar i = 0; i < c_NUM_FIELDS; i++) begin : g_field
            assign w_max[i] = field_max(i, r_time[c_F_MONTH], r_time[c_F_YEAR]);
            rtc_bcd_inc u_inc (
                .value      (r_time[i]),
                .min        (field_min(i)),
                .max        (w_max[i]),
                .next_value (w_inc_val[i]),
                .carry      (w_carry[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < c_NUM_FIELDS; i++) r_time[i] <= field_min(i);
        end else begin
            for (int i = 0; i < c_NUM_FIELDS; i++) begin
                if (w_reg_wr && w_addr_is_time && (w_tidx == 3'(i))) r_time[i] <= w_din;
                else if (w_inc_en[i])                               r_time[i] <= w_inc_val[i];
            end
        end
    end

    assign data_out = r_data_out;
    assign data_oe  = r_data_oe;
    assign tick     = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rtc_bus_responder
// Description : Scoreboard bench for rtc_bus_responder bus reads and calendar.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_responder;

    localparam int c_TICK_DIV    = 80;
    localparam int c_SYNC_STAGES = 2;
    localparam logic [7:0] c_CTRL = 8'h00, c_SEC = 8'h21, c_MIN = 8'h22, c_HOUR = 8'h23,
                           c_DATE = 8'h24, c_MONTH = 8'h25, c_YEAR = 8'h26,
                           c_DOW = 8'h27, c_WEEK = 8'h28;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ChipSelect = 1'b1, Read = 1'b1, Write = 1'b1, AoD = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe, tick;

    int n_cmp = 0, n_err = 0, cyc = 0, oe_hi_cycles = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } rd_exp_t;
    rd_exp_t exp_q[$];
    logic    oe_prev = 1'b0;

    rtc_bus_responder #(
        .TICK_DIV    (c_TICK_DIV),
        .SYNC_STAGES (c_SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .ChipSelect (ChipSelect),
        .Read       (Read),
        .Write      (Write),
        .AoD        (AoD),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .tick       (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read data is compared on the first cycle the DUT enables its driver
    always @(negedge clk) begin
        rd_exp_t e;
        if (!Reset && data_oe) oe_hi_cycles++;
        if (!Reset && data_oe && !oe_prev) begin
            if (exp_q.size() == 0) begin
                check_val("oe_unexpected", 32'(data_oe), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val($sformatf("rd_%02h", e.addr), 32'(data_out), 32'(e.val));
            end
        end
        oe_prev = data_oe;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe_write(input logic aod, input logic [7:0] val);
        ChipSelect = 1'b0; AoD = aod; data_in = val;
        step(1); Write = 1'b0;
        step(4); Write = 1'b1;
        step(4); ChipSelect = 1'b1;
        step(3);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] val);
        strobe_write(1'b0, addr);
        strobe_write(1'b1, val);
    endtask

    task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp);
        strobe_write(1'b0, addr);
        ChipSelect = 1'b0; AoD = 1'b1;
        step(1); Read = 1'b0;
        exp_q.push_back('{addr: addr, val: exp});
        step(5); Read = 1'b1;
        step(3); ChipSelect = 1'b1;
        step(3);
    endtask

    task automatic sync_tick();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!tick && n < 4 * c_TICK_DIV);
        if (!tick) check_val("tick_timeout", 32'd0, 32'd1);
    endtask

    // Unhalt right after a tick, let exactly one tick count, then halt again
    task automatic run_one_tick();
        sync_tick();
        bus_write(c_CTRL, 8'h00);
        sync_tick();
        bus_write(c_CTRL, 8'h01);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus_write(c_HOUR, h);
        bus_write(c_MIN, m);
        bus_write(c_SEC, s);
    endtask

    initial begin
        int c1, cq, oe_snap, n;

        step(3);
        check_val("rst_oe", 32'(data_oe), 32'd0);
        check_val("rst_dout", 32'(data_out), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        Reset = 1'b0;
        step(1);

        // Reset values; seconds read before the first tick, then halt
        bus_read(c_SEC, 8'h00);
        bus_write(c_CTRL, 8'h01);
        bus_read(c_MIN, 8'h00);
        bus_read(c_HOUR, 8'h00);
        bus_read(c_DATE, 8'h01);
        bus_read(c_MONTH, 8'h01);
        bus_read(c_YEAR, 8'h00);
        bus_read(c_DOW, 8'h01);
        bus_read(c_WEEK, 8'h01);
        bus_read(c_CTRL, 8'h01);
        bus_write(8'h30, 8'h55);
        bus_read(8'h30, 8'h00);
        bus_read(8'h20, 8'h00);

        // 23:59:59 rolls the day
        set_time(8'h23, 8'h59, 8'h59);
        run_one_tick();
        bus_read(c_SEC, 8'h00);
        bus_read(c_MIN, 8'h00);
        bus_read(c_HOUR, 8'h00);
        bus_read(c_DATE, 8'h02);
        bus_read(c_DOW, 8'h02);
        bus_read(c_MONTH, 8'h01);

        // February in leap and non-leap years
        bus_write(c_YEAR, 8'h24);
        bus_write(c_MONTH, 8'h02);
        bus_write(c_DATE, 8'h28);
        set_time(8'h23, 8'h59, 8'h59);
        run_one_tick();
        bus_read(c_DATE, 8'h29);
        bus_read(c_MONTH, 8'h02);
        bus_write(c_YEAR, 8'h23);
        bus_write(c_DATE, 8'h28);
        set_time(8'h23, 8'h59, 8'h59);
        run_one_tick();
        bus_read(c_DATE, 8'h01);
        bus_read(c_MONTH, 8'h03);

        // Halt freezes time
        bus_write(c_SEC, 8'h30);
        sync_tick(); sync_tick(); sync_tick();
        bus_read(c_SEC, 8'h30);
        run_one_tick();
        bus_read(c_SEC, 8'h31);

        // ChipSelect lost before the data-phase Write rising edge
        strobe_write(1'b0, c_SEC);
        ChipSelect = 1'b0; AoD = 1'b1; data_in = 8'h77;
        step(1); Write = 1'b0;
        step(4); ChipSelect = 1'b1;
        step(3); Write = 1'b1;
        step(3);
        bus_read(c_SEC, 8'h31);
        bus_write(c_SEC, 8'h45);
        bus_read(c_SEC, 8'h45);

        // Seconds write committing on the tick cycle
        sync_tick();
        cq = cyc;
        oe_snap = oe_hi_cycles;
        bus_write(c_CTRL, 8'h00);
        strobe_write(1'b0, c_SEC);
        ChipSelect = 1'b0; AoD = 1'b1; data_in = 8'h10;
        step(1); Write = 1'b0;
        n = 0;
        while (cyc < cq + c_TICK_DIV - 2 && n < 4 * c_TICK_DIV) begin
            step(1);
            n++;
        end
        Write = 1'b1;
        step(4); ChipSelect = 1'b1;
        step(3);
        bus_write(c_CTRL, 8'h01);
        check_val("oe_quiet", 32'(oe_hi_cycles - oe_snap), 32'd0);
        bus_read(c_SEC, 8'h11);

        sync_tick();
        c1 = cyc;
        sync_tick();
        check_val("tick_period", 32'(cyc - c1), 32'(c_TICK_DIV));

        // Day-of-week and week wrap, 30-day month rollover
        bus_write(c_DOW, 8'h07);
        bus_write(c_WEEK, 8'h52);
        bus_write(c_DATE, 8'h30);
        bus_write(c_MONTH, 8'h06);
        set_time(8'h23, 8'h59, 8'h59);
        run_one_tick();
        bus_read(c_DOW, 8'h01);
        bus_read(c_WEEK, 8'h01);
        bus_read(c_DATE, 8'h01);
        bus_read(c_MONTH, 8'h07);

        // Year wrap
        bus_write(c_YEAR, 8'h99);
        bus_write(c_MONTH, 8'h12);
        bus_write(c_DATE, 8'h31);
        set_time(8'h23, 8'h59, 8'h59);
        run_one_tick();
        bus_read(c_YEAR, 8'h00);
        bus_read(c_MONTH, 8'h01);
        bus_read(c_DATE, 8'h01);
        bus_read(c_DOW, 8'h02);
        bus_read(c_WEEK, 8'h01);

        // Non-BCD seconds wrap to zero
        bus_write(c_SEC, 8'h3F);
        run_one_tick();
        bus_read(c_SEC, 8'h00);

        // Reset in the middle of an address phase
        ChipSelect = 1'b0; AoD = 1'b0; data_in = 8'h25;
        step(1); Write = 1'b0;
        step(3); Reset = 1'b1;
        step(2); Reset = 1'b0; Write = 1'b1; ChipSelect = 1'b1;
        step(3);
        bus_read(c_MIN, 8'h00);
        bus_read(c_MONTH, 8'h01);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        check_val("sb_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
